// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: drives LFSR patterns into a circuit-under-test and folds
// its responses into a 16-bit MISR signature.
module bist_seq_ctrl #(
  parameter int PAT_W = 8,
  parameter int IN_W  = 3,
  parameter int OUT_W = 6
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] num_pat,
  input  logic [15:0]      lfsr_seed,
  output logic             cut_rst,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic [PAT_W-1:0] pat_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_APPLY,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             init_cnt_q, init_cnt_d;
  logic [PAT_W-1:0] num_pat_q, num_pat_d;
  logic [PAT_W-1:0] pat_idx_q, pat_idx_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      misr_q, misr_d;
  logic [IN_W-1:0]  last_pat_q, last_pat_d;
  logic [15:0]      misr_in;

  // Shared shift/feedback step used by both the pattern LFSR and the MISR.
  function automatic logic [15:0] poly_shift(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Zero-extend the CUT response to the MISR width.
  always_comb begin
    misr_in = '0;
    misr_in[OUT_W-1:0] = cut_out;
  end

  // Next-state, datapath updates and outputs; abort overrides the normal flow.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    num_pat_d  = num_pat_q;
    pat_idx_d  = pat_idx_q;
    lfsr_d     = lfsr_q;
    misr_d     = misr_q;
    last_pat_d = last_pat_q;
    cut_rst    = 1'b0;
    cut_in     = '0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_INIT;
          init_cnt_d = 1'b0;
          num_pat_d  = num_pat;
          lfsr_d     = (lfsr_seed == 16'h0000) ? 16'h0001 : lfsr_seed;
          // Clear on entry so the signature reads zero throughout INIT.
          misr_d     = 16'h0000;
          pat_idx_d  = '0;
        end
      end
      S_INIT: begin
        cut_rst    = 1'b1;
        init_cnt_d = 1'b1;
        if (init_cnt_q) begin
          state_d = (num_pat_q != '0) ? S_APPLY : S_DONE;
        end
      end
      S_APPLY: begin
        cut_in     = lfsr_q[IN_W-1:0];
        last_pat_d = lfsr_q[IN_W-1:0];
        lfsr_d     = poly_shift(lfsr_q);
        misr_d     = poly_shift(misr_q) ^ misr_in;
        pat_idx_d  = pat_idx_q + 1'b1;
        if (pat_idx_d == num_pat_q) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // One extra capture for the response to the final pattern.
        cut_in  = last_pat_q;
        misr_d  = poly_shift(misr_q) ^ misr_in;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      cut_rst    = 1'b0;
      done       = 1'b0;
      pat_idx_d  = pat_idx_q;
      misr_d     = misr_q;
      lfsr_d     = lfsr_q;
      last_pat_d = last_pat_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      state_q    <= S_IDLE;
      init_cnt_q <= 1'b0;
      num_pat_q  <= '0;
      pat_idx_q  <= '0;
      lfsr_q     <= 16'h0001;
      misr_q     <= 16'h0000;
      last_pat_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      num_pat_q  <= num_pat_d;
      pat_idx_q  <= pat_idx_d;
      lfsr_q     <= lfsr_d;
      misr_q     <= misr_d;
      last_pat_q <= last_pat_d;
    end
  end

  assign signature = misr_q;
  assign pat_idx   = pat_idx_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Self-checking bench for bist_seq_ctrl: a cycle-indexed run model plus
// directed runs with hand-computed expectations.
module tb_bist_seq_ctrl;

  localparam int PAT_W = 8;
  localparam int IN_W  = 3;
  localparam int OUT_W = 6;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] num_pat;
  logic [15:0]      lfsr_seed;
  logic             cut_rst;
  logic [IN_W-1:0]  cut_in;
  logic [OUT_W-1:0] cut_out;
  logic             busy;
  logic             done;
  logic [15:0]      signature;
  logic [PAT_W-1:0] pat_idx;

  int n_cmp = 0;
  int n_bad = 0;

  // CUT emulation: mode 0 = constant response, mode 1 = simple logic of cut_in.
  bit               cut_mode;
  logic [OUT_W-1:0] cut_const;

  function automatic logic [OUT_W-1:0] cut_fn(input bit mode, input logic [OUT_W-1:0] cnst,
                                              input logic [IN_W-1:0] cin);
    if (!mode) return cnst;
    return {cin, cin ^ 3'b101};
  endfunction

  assign cut_out = cut_fn(cut_mode, cut_const, cut_in);

  bist_seq_ctrl #(.PAT_W(PAT_W), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .blif_clk_net  (clk),
    .blif_reset_net(rst_n),
    .start         (start),
    .abort         (abort),
    .num_pat       (num_pat),
    .lfsr_seed     (lfsr_seed),
    .cut_rst       (cut_rst),
    .cut_in        (cut_in),
    .cut_out       (cut_out),
    .busy          (busy),
    .done          (done),
    .signature     (signature),
    .pat_idx       (pat_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // A run is described by its cycle index t (1 = first cycle after start is
  // taken): INIT at t=1..2, APPLY at t=3..n+2, FLUSH at t=n+3, DONE last.
  bit               m_valid = 0;
  bit               m_run   = 0;
  int               m_t, m_n;
  logic [15:0]      m_lfsr, m_misr;
  logic [PAT_W-1:0] m_pidx;
  logic [IN_W-1:0]  m_last;

  function automatic logic [15:0] shift16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int done_t();
    return (m_n == 0) ? 3 : m_n + 4;
  endfunction

  function automatic bit in_apply();
    return m_run && (m_t >= 3) && (m_t <= m_n + 2);
  endfunction

  function automatic bit in_flush();
    return m_run && (m_n > 0) && (m_t == m_n + 3);
  endfunction

  function automatic logic [IN_W-1:0] exp_cut_in();
    if (in_apply()) return m_lfsr[IN_W-1:0];
    if (in_flush()) return m_last;
    return '0;
  endfunction

  initial begin
    logic [OUT_W-1:0] co;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_valid = 1;
        m_run   = 0;
        m_lfsr  = 16'h0001;
        m_misr  = 16'h0000;
        m_pidx  = '0;
        m_last  = '0;
      end else if (!m_run) begin
        if (start && !abort) begin
          m_run  = 1;
          m_t    = 1;
          m_n    = int'(num_pat);
          m_lfsr = (lfsr_seed == 16'h0000) ? 16'h0001 : lfsr_seed;
          m_misr = 16'h0000;
          m_pidx = '0;
        end
      end else if (abort) begin
        m_run = 0;
      end else begin
        if (in_apply()) begin
          co     = cut_fn(cut_mode, cut_const, m_lfsr[IN_W-1:0]);
          m_last = m_lfsr[IN_W-1:0];
          m_lfsr = shift16(m_lfsr);
          m_misr = shift16(m_misr) ^ {10'd0, co};
          m_pidx = m_pidx + 1'b1;
        end else if (in_flush()) begin
          co     = cut_fn(cut_mode, cut_const, m_last);
          m_misr = shift16(m_misr) ^ {10'd0, co};
        end
        if (m_t == done_t()) m_run = 0;
        else m_t++;
      end
    end
  end

  // Cycle-by-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_run && (m_t == done_t()) && !abort));
        chk("cut_rst", 32'(cut_rst), 32'(m_run && (m_t <= 2) && !abort));
        chk("cut_in", 32'(cut_in), 32'(exp_cut_in()));
        chk("signature", 32'(signature), 32'(m_misr));
        chk("pat_idx", 32'(pat_idx), 32'(m_pidx));
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  logic             o_busy [0:300];
  logic             o_rst  [0:300];
  logic [IN_W-1:0]  o_cin  [0:300];
  logic [15:0]      o_sig  [0:300];
  logic [PAT_W-1:0] o_pidx [0:300];
  int               last_lat;

  // Entered and left at posedge+2. Cycle k is the k-th cycle after start is sampled.
  task automatic do_run(input string tag, input int n, input logic [15:0] seed,
                        input int abort_k, input int rst_k, input int restart_k,
                        input int exp_lat);
    int lat;
    lat       = 0;
    num_pat   = PAT_W'(n);
    lfsr_seed = seed;
    start     = 1'b1;
    @(posedge clk); #2;
    start     = 1'b0;
    num_pat   = PAT_W'($urandom);
    lfsr_seed = 16'($urandom);
    for (int k = 1; k <= n + 10; k++) begin
      if (k == abort_k) abort = 1'b1;
      if (k == rst_k) rst_n = 1'b0;
      if (k == restart_k) begin
        start     = 1'b1;
        num_pat   = 8'd1;
        lfsr_seed = 16'hFFFF;
      end
      @(negedge clk);
      o_busy[k] = busy;
      o_rst[k]  = cut_rst;
      o_cin[k]  = cut_in;
      o_sig[k]  = signature;
      o_pidx[k] = pat_idx;
      if (done && lat == 0) lat = k;
      @(posedge clk); #2;
      abort = 1'b0;
      rst_n = 1'b1;
      start = 1'b0;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    last_lat = lat;
    $display("run %-10s n=%0d seed=0x%04h done_cycle=%0d sig=0x%04h pat_idx=%0d",
             tag, n, seed, lat, signature, pat_idx);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    num_pat   = '0;
    lfsr_seed = '0;
    cut_mode  = 1'b0;
    cut_const = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sig", 32'(signature), 32'h0000);
    chk("rst_pidx", 32'(pat_idx), 32'd0);
    chk("rst_cut_in", 32'(cut_in), 32'd0);
    @(posedge clk); #2;

    // Zero patterns: two INIT cycles then DONE.
    do_run("zero", 0, 16'hBEEF, 0, 0, 0, 3);
    chk("zero_cut_rst1", 32'(o_rst[1]), 32'd1);
    chk("zero_cut_rst2", 32'(o_rst[2]), 32'd1);
    chk("zero_sig", 32'(o_sig[3]), 32'h0000);
    chk("zero_pidx", 32'(o_pidx[3]), 32'd0);

    // Seed 0 replaced by 1; constant zero response.
    do_run("seed0", 2, 16'h0000, 0, 0, 0, 6);
    chk("seed0_cin1", 32'(o_cin[3]), 32'h1);
    chk("seed0_cin2", 32'(o_cin[4]), 32'h2);
    chk("seed0_sig", 32'(o_sig[6]), 32'h0000);
    chk("seed0_pidx", 32'(o_pidx[6]), 32'd2);

    // One pattern, response 0x01: MISR 0x0001 after APPLY, 0x0003 after FLUSH.
    cut_const = 6'h01;
    do_run("one", 1, 16'h0001, 0, 0, 0, 5);
    chk("one_sig_apply", 32'(o_sig[4]), 32'h0001);
    chk("one_sig_flush", 32'(o_sig[5]), 32'h0003);
    chk("one_cin_flush", 32'(o_cin[4]), 32'h1);

    // Emulated CUT responding to the pattern, longer run.
    cut_mode = 1'b1;
    do_run("cut20", 20, 16'hACE1, 0, 0, 0, 24);
    chk("cut20_pidx", 32'(o_pidx[24]), 32'd20);

    // Abort in the second APPLY cycle: one pattern counted, then idle.
    do_run("abort_app", 10, 16'h1357, 4, 0, 0, 0);
    chk("abort_busy", 32'(o_busy[5]), 32'd0);
    chk("abort_pidx", 32'(o_pidx[5]), 32'd1);

    // Abort during INIT and during DONE: no done pulse either way.
    do_run("abort_init", 4, 16'h2222, 2, 0, 0, 0);
    chk("abort_init_sig", 32'(o_sig[3]), 32'h0000);
    do_run("abort_done", 1, 16'h3333, 5, 0, 0, 0);
    chk("abort_done_busy", 32'(o_busy[6]), 32'd0);

    // Reset mid-APPLY, then a full run straight afterwards.
    do_run("rst_mid", 8, 16'h4444, 0, 5, 0, 0);
    chk("rstmid_busy", 32'(o_busy[6]), 32'd0);
    chk("rstmid_sig", 32'(o_sig[6]), 32'h0000);
    chk("rstmid_pidx", 32'(o_pidx[6]), 32'd0);
    chk("rstmid_cin", 32'(o_cin[6]), 32'd0);
    do_run("after_rst", 3, 16'h1234, 0, 0, 0, 7);

    // Start re-pulsed while busy is ignored.
    do_run("restart", 5, 16'h5A5A, 0, 0, 3, 9);
    chk("restart_pidx", 32'(o_pidx[9]), 32'd5);

    // Start together with abort in IDLE: nothing starts.
    start   = 1'b1;
    abort   = 1'b1;
    num_pat = 8'd4;
    @(posedge clk); #2;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("start_abort_busy", 32'(busy), 32'd0);
      @(posedge clk); #2;
    end

    // Largest count: pat_idx reaches 255 without wrapping.
    do_run("max", 255, 16'hC0DE, 0, 0, 0, 259);
    chk("max_pidx", 32'(o_pidx[259]), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bist_seq_ctrl.md
BIST_SEQ_CTRL -- requirements
Module: bist_seq_ctrl

Interface
REQ-001 SHALL provide parameters (name, default, meaning): PAT_W, 8, pattern-count width; IN_W, 3, CUT input width (1..16); OUT_W, 6, CUT output width (1..16).
REQ-002 SHALL have ports (name direction width meaning): blif_clk_net in 1 sole clock, all state on rising edge.
REQ-003 blif_reset_net in 1: synchronous, active-low reset, sampled on rising edge of blif_clk_net.
REQ-004 start in 1: request one test run, sampled in IDLE only.
REQ-005 abort in 1: terminate a run.
REQ-006 num_pat in PAT_W: number of patterns to apply, latched on start.
REQ-007 lfsr_seed in 16: pattern LFSR seed, latched on start.
REQ-008 cut_rst out 1: active-high reset to circuit-under-test (CUT).
REQ-009 cut_in out IN_W: stimulus to CUT primary inputs.
REQ-010 cut_out in OUT_W: CUT primary outputs.
REQ-011 busy out 1; done out 1 (single-cycle pulse); signature out 16; pat_idx out PAT_W.

Function
REQ-012 SHALL implement FSM states IDLE, INIT, APPLY, FLUSH, DONE.
REQ-013 IDLE: start=1 and abort=0 -> INIT; latch num_pat and seed; seed 0x0000 is replaced by 0x0001.
REQ-014 INIT lasts exactly 2 cycles: cut_rst=1, MISR cleared to 0, pat_idx cleared to 0. Exit to APPLY if latched num_pat>0, else to DONE.
REQ-015 APPLY: cut_in = LFSR[IN_W-1:0] each cycle; cut_rst=0.
REQ-016 APPLY, end of each cycle: LFSR, MISR and pat_idx (+1) advance; after the cycle where pat_idx reaches num_pat, go to FLUSH.
REQ-017 LFSR update: {q[14:0], q[15]^q[13]^q[12]^q[10]}.
REQ-018 MISR update: {m[14:0], m[15]^m[13]^m[12]^m[10]} XOR zero-extended cut_out.
REQ-019 FLUSH lasts 1 cycle: MISR absorbs cut_out once more (response to last pattern); LFSR holds; cut_in holds the last pattern.
REQ-020 DONE lasts 1 cycle: done=1, then IDLE.
REQ-021 signature SHALL equal MISR at all times; it holds after DONE until the next INIT.
REQ-022 pat_idx holds its final value in IDLE.
REQ-023 busy=1 in INIT, APPLY, FLUSH and DONE; busy=0 in IDLE.
REQ-024 Latency from start sampled in IDLE to done pulse: num_pat+4 cycles; 3 cycles when num_pat=0.
REQ-025 start while busy SHALL be ignored; num_pat and seed inputs are ignored while busy.
REQ-026 abort=1 in any non-IDLE state, including DONE: next state IDLE, no done pulse, cut_rst=0, signature and pat_idx frozen at current value.
REQ-027 abort and start together in IDLE: abort wins, remain IDLE.
REQ-028 pat_idx SHALL count without wrap; maximum num_pat = 2^PAT_W-1 patterns.
REQ-029 cut_in is 0 in IDLE, INIT and DONE.

Reset
REQ-030 blif_reset_net=0 at a rising edge SHALL force: state IDLE, busy 0, done 0, cut_rst 0, cut_in 0, signature 0x0000, pat_idx 0, LFSR 0x0001; this overrides all other inputs.
REQ-031 Reset mid-run SHALL abandon the run with no done pulse; a start is accepted on the first cycle after reset deasserts.

Verification
REQ-032 num_pat=0, start pulse -> INIT 2 cycles with cut_rst=1, done 3 cycles after start, signature 0x0000, pat_idx 0.
REQ-033 seed 0x0000, num_pat=2, cut_out=0 -> cut_in 3'b001 then 3'b010; signature 0x0000; done at cycle 6; pat_idx 2.
REQ-034 seed 0x0001, num_pat=1, cut_out=6'h01 -> MISR 0x0001 after APPLY, signature 0x0003 after FLUSH, done at cycle 5.
REQ-035 abort asserted in 2nd APPLY cycle of num_pat=10 -> IDLE next cycle, busy 0, no done, pat_idx 1 or 2 held (per REQ-016 timing).
REQ-036 blif_reset_net=0 during APPLY -> all outputs at reset values next cycle; new start then gives a full, correct run.
REQ-037 start re-pulsed while busy and start+abort in IDLE -> no effect on the run in progress, no run started.
